// File: rtl/mmcm_phase_arbiter.sv
// mmcm_phase_arbiter
//   Round-robin arbiter that shares one MMCM phase-shift counter's absolute-phase
//   write port among NUM_REQ requesters. One transaction is in flight at a time.
//   Each transaction ends with a one-cycle ack to the granted requester.
//
// Ports (all on the psclk domain):
//   clk          phase-shift clock (same as the counter's psclk)
//   rst          synchronous active-high reset
//   req          level request per requester, held until ack
//   req_phase    target phase per requester, slice i = [i*PHASE_WIDTH +: PHASE_WIDTH]
//   ack          one-cycle done pulse to the granted requester
//   busy         transaction in progress; stays high through the ack cycle
//   grant_id     index of the current or last granted requester
//   timeout_err  sticky WAIT_READY timeout flag (tied 0 unless the timeout is built in)
//   ps_we/ps_din write strobe and target phase to the counter
//   ps_ready     counter idle and MMCM locked
//   ps_dout      counter's current phase
//
// Build option: define MMCM_PHASE_ARB_TIMEOUT_EN to bound WAIT_READY to TIMEOUT_CYCLES.

module mmcm_phase_arbiter #(
  parameter int unsigned PHASE_WIDTH    = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PHASE_WIDTH-1:0] req_phase,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           busy,
  output logic [2:0]                     grant_id,
  output logic                           timeout_err,
  output logic                           ps_we,
  output logic [PHASE_WIDTH-1:0]         ps_din,
  input  logic                           ps_ready,
  input  logic [PHASE_WIDTH-1:0]         ps_dout
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitLow, StWaitReady, StDone} state_e;

  state_e                 state;
  logic [2:0]             rr_ptr;
  logic                   holdoff;
  logic [PHASE_WIDTH-1:0] tgt;

  // Round-robin winner: rotate req so that index rr_ptr+1 lands on bit 0, take the
  // lowest set bit, then rotate the position back to an absolute index.
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [NUM_REQ-1:0]     req_rot;
  logic [3:0]             rr_start;
  logic [3:0]             pos;
  logic [3:0]             sum;
  logic                   win_valid;
  logic [2:0]             win_id;
  logic [PHASE_WIDTH-1:0] win_phase;
  logic [NUM_REQ-1:0]     grant_oh;

  always_comb begin
    rr_start  = 4'(rr_ptr) + 4'd1;
    if (rr_start >= 4'(NUM_REQ)) rr_start = 4'd0;
    req_dbl   = {req, req};
    req_rot   = NUM_REQ'(req_dbl >> rr_start);
    win_valid = 1'b0;
    pos       = 4'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_valid = 1'b1;
        pos       = 4'(i);
      end
    end
    sum = rr_start + pos;
    if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
    win_id    = sum[2:0];
    win_phase = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == win_id) win_phase = req_phase[j*PHASE_WIDTH +: PHASE_WIDTH];
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_oh[k] = (3'(k) == grant_id);
    end
  end

`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES >= 4096) ? $clog2(TIMEOUT_CYCLES + 1) : 12;
  logic [CntW-1:0] tmo_cnt;
  logic            tmo_hit;   // current transaction ended by timeout
  logic [2:0]      err_id;    // grant_id whose timeout set timeout_err
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      ack      <= '0;
      busy     <= 1'b0;
      grant_id <= 3'd0;
      ps_we    <= 1'b0;
      ps_din   <= '0;
      rr_ptr   <= 3'(NUM_REQ - 1);
      holdoff  <= 1'b0;
      tgt      <= '0;
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      tmo_hit     <= 1'b0;
      err_id      <= 3'd0;
      timeout_err <= 1'b0;
`endif
    end else begin
      ack   <= '0;
      ps_we <= 1'b0;
      unique case (state)
        StIdle: begin
          if (holdoff) begin
            // Gives the just-acked requester one cycle to drop req.
            holdoff <= 1'b0;
            busy    <= 1'b0;
          end else if (win_valid && ps_ready) begin
            tgt      <= win_phase;
            grant_id <= win_id;
            busy     <= 1'b1;
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
            tmo_hit  <= 1'b0;
`endif
            // Raw bit compare: already at target means nothing to write.
            state    <= (win_phase == ps_dout) ? StDone : StIssue;
          end else begin
            busy <= 1'b0;
          end
        end
        StIssue: begin
          // Lock loss holds off the write until the counter is ready again.
          if (ps_ready) begin
            ps_we  <= 1'b1;
            ps_din <= tgt;
            state  <= StWaitLow;
          end
        end
        StWaitLow: begin
          // Skips the cycle where ps_ready has not yet dropped for the new write.
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= StWaitReady;
        end
        StWaitReady: begin
          if (ps_ready) begin
            state <= StDone;
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
          end else if (tmo_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit <= 1'b1;
            state   <= StDone;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        StDone: begin
          ack     <= grant_oh;
          rr_ptr  <= grant_id;
          holdoff <= 1'b1;
          state   <= StIdle;
`ifdef MMCM_PHASE_ARB_TIMEOUT_EN
          if (tmo_hit) begin
            timeout_err <= 1'b1;
            err_id      <= grant_id;
          end else if (grant_id == err_id) begin
            timeout_err <= 1'b0;
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
